seq_signed_multiplier: RTL

SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

---
 rtl/seq_signed_multiplier_if.sv | 21 ++
 rtl/seq_signed_multiplier.sv | 105 ++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier_if.sv
// Handshake and data bundle for seq_signed_multiplier.
// The master drives start/operands; the slave (the multiplier) returns status and product.
interface seq_signed_multiplier_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Sequential radix-2 signed 32x32 multiplier (sign-magnitude shift-add, sign fixed up at the end).
// Define MULT_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier magnitude is zero.
module seq_signed_multiplier (
  input  logic                    clk,
  input  logic                    rst,
  seq_signed_multiplier_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] acc;
  logic [63:0] mcand_mag;
  logic [31:0] mplier_mag;
  logic [5:0]  count;
  logic        sign;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc_next;
  logic [31:0] mplier_shift;
  logic        calc_last;

  // -2^31 negates to itself, which is exactly its unsigned magnitude
  assign a_mag = bus.multiplicand[31] ? (~bus.multiplicand + 32'd1) : bus.multiplicand;
  assign b_mag = bus.multiplier[31]   ? (~bus.multiplier + 32'd1)   : bus.multiplier;

  assign acc_next     = mplier_mag[0] ? (acc + mcand_mag) : acc;
  assign mplier_shift = mplier_mag >> 1;

`ifdef MULT_EARLY_TERM_EN
  assign calc_last = (mplier_shift == 32'd0);
`else
  assign calc_last = (count == 6'd31);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= 64'd0;
      mcand_mag  <= 64'd0;
      mplier_mag <= 32'd0;
      count      <= 6'd0;
      sign       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_mag  <= {32'd0, a_mag};
            mplier_mag <= b_mag;
            sign       <= bus.multiplicand[31] ^ bus.multiplier[31];
            acc        <= 64'd0;
            count      <= 6'd0;
            busy_q     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          acc        <= acc_next;
          mcand_mag  <= mcand_mag << 1;
          mplier_mag <= mplier_shift;
          count      <= count + 6'd1;
          if (calc_last) begin
            state <= FIX;
          end
        end
        FIX: begin
          {hi_q, lo_q} <= sign ? (~acc + 64'd1) : acc;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
